// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war controller:
// FSM state encoding and winner codes.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY,
    PAUSE,
    OVER
  } tow_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b10;
  localparam logic [1:0] WIN_R    = 2'b01;

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for one synchronized key level.
// Emits a single-cycle event on the first cycle the key reads high.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic ev
);

  logic key_q;

  always_ff @(posedge clk) begin
    if (!reset) key_q <= 1'b0;
    else        key_q <= key;
  end

  assign ev = key & ~key_q;

endmodule

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game controller: playfield light position,
// round scoring and the pause / recenter / game-over sequence.
module tug_of_war_ctrl
  import tow_pkg::*;
#(
  parameter int N_LIGHTS     = 9,
  parameter int SCORE_MAX    = 7,
  parameter int PAUSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_L,
  input  logic                key_R,
  output logic [N_LIGHTS-1:0] lights,
  output logic [2:0]          score_L,
  output logic [2:0]          score_R,
  output logic [1:0]          winner,
  output logic                game_over
);

  localparam int C  = N_LIGHTS / 2;
  localparam int CW = $clog2(PAUSE_CYCLES + 1);

  localparam logic [N_LIGHTS-1:0] CENTER =
    {{(N_LIGHTS-1){1'b0}}, 1'b1} << C;
  localparam logic [2:0]    SMAX  = 3'(SCORE_MAX);
  localparam logic [CW-1:0] PLOAD = CW'(PAUSE_CYCLES - 1);

  tow_state_t state, state_n;

  logic [N_LIGHTS-1:0] lights_n;
  logic [2:0]          score_L_n;
  logic [2:0]          score_R_n;
  logic [1:0]          winner_n;
  logic                game_over_n;
  logic [CW-1:0]       cnt, cnt_n;

  logic ev_l, ev_r;
  logic mv_l, mv_r;

  key_edge u_edge_l (
    .clk   (clk),
    .reset (reset),
    .key   (key_L),
    .ev    (ev_l)
  );

  key_edge u_edge_r (
    .clk   (clk),
    .reset (reset),
    .key   (key_R),
    .ev    (ev_r)
  );

  // Both players pulling together cancel out.
  assign mv_l = ev_l & ~ev_r;
  assign mv_r = ev_r & ~ev_l;

  always_comb begin
    state_n     = state;
    lights_n    = lights;
    score_L_n   = score_L;
    score_R_n   = score_R;
    winner_n    = winner;
    game_over_n = game_over;
    cnt_n       = cnt;

    unique case (state)
      PLAY: begin
        if (mv_l) begin
          if (lights[N_LIGHTS-1]) begin
            lights_n = '0;
            if (score_L < SMAX)
              score_L_n = score_L + 3'd1;
            cnt_n   = PLOAD;
            state_n = PAUSE;
          end else begin
            lights_n = lights << 1;
          end
        end else if (mv_r) begin
          if (lights[0]) begin
            lights_n = '0;
            if (score_R < SMAX)
              score_R_n = score_R + 3'd1;
            cnt_n   = PLOAD;
            state_n = PAUSE;
          end else begin
            lights_n = lights >> 1;
          end
        end
      end

      PAUSE: begin
        lights_n = '0;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          unique case (1'b1)
            (score_L == SMAX): begin
              state_n     = OVER;
              game_over_n = 1'b1;
              winner_n    = WIN_L;
            end
            (score_R == SMAX): begin
              state_n     = OVER;
              game_over_n = 1'b1;
              winner_n    = WIN_R;
            end
            default: begin
              lights_n = CENTER;
              state_n  = PLAY;
            end
          endcase
        end
      end

      OVER: begin
      end

      default: state_n = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= PLAY;
      lights    <= CENTER;
      score_L   <= '0;
      score_R   <= '0;
      winner    <= WIN_NONE;
      game_over <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      lights    <= lights_n;
      score_L   <= score_L_n;
      score_R   <= score_R_n;
      winner    <= winner_n;
      game_over <= game_over_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Directed scoreboard bench for tug_of_war_ctrl
// (N_LIGHTS=9, SCORE_MAX=2, PAUSE_CYCLES=4).
module tb_tug_of_war_ctrl;

  logic       clk;
  logic       reset;
  logic       key_L;
  logic       key_R;
  logic [8:0] lights;
  logic [2:0] score_L;
  logic [2:0] score_R;
  logic [1:0] winner;
  logic       game_over;

  typedef struct {
    logic [8:0] l;
    logic [2:0] sl;
    logic [2:0] sr;
    logic       go;
    logic [1:0] w;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int stepn = 0;

  logic [8:0] el;
  logic [2:0] esl, esr;
  logic       ego;
  logic [1:0] ew;

  logic       armed = 1'b0;
  logic       rst_at_edge = 1'b0;
  logic [2:0] prev_l = '0;
  logic [2:0] prev_r = '0;

  localparam logic [8:0] CEN = 9'b000010000;

  tug_of_war_ctrl #(
    .N_LIGHTS     (9),
    .SCORE_MAX    (2),
    .PAUSE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_L     (key_L),
    .key_R     (key_R),
    .lights    (lights),
    .score_L   (score_L),
    .score_R   (score_R),
    .winner    (winner),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] oh(input int i);
    logic [8:0] one;
    one = 9'd1;
    return one << i;
  endfunction

  task automatic st(input logic kl, input logic kr, input logic rs);
    exp_t e;
    exp_t g;
    @(negedge clk);
    key_L = kl;
    key_R = kr;
    reset = rs;
    e.l  = el;
    e.sl = esl;
    e.sr = esr;
    e.go = ego;
    e.w  = ew;
    sb.push_back(e);
    @(posedge clk);
    #1;
    stepn++;
    g = sb.pop_front();
    tests++;
    assert (lights === g.l) else begin
      fails++;
      $error("FAIL lights step %0d: got %b want %b", stepn, lights, g.l);
    end
    tests++;
    assert (score_L === g.sl) else begin
      fails++;
      $error("FAIL score_L step %0d: got %0d want %0d", stepn, score_L, g.sl);
    end
    tests++;
    assert (score_R === g.sr) else begin
      fails++;
      $error("FAIL score_R step %0d: got %0d want %0d", stepn, score_R, g.sr);
    end
    tests++;
    assert (game_over === g.go) else begin
      fails++;
      $error("FAIL game_over step %0d: got %b want %b", stepn, game_over, g.go);
    end
    tests++;
    assert (winner === g.w) else begin
      fails++;
      $error("FAIL winner step %0d: got %b want %b", stepn, winner, g.w);
    end
  endtask

  always @(posedge clk) rst_at_edge = ~reset;

  always @(negedge clk) begin
    if (armed) begin
      tests++;
      assert ($countones(lights) <= 1) else begin
        fails++;
        $error("FAIL onehot: lights %b", lights);
      end
      if (!rst_at_edge) begin
        tests++;
        assert (score_L >= prev_l && score_R >= prev_r) else begin
          fails++;
          $error("FAIL score_monotonic: got %0d/%0d was %0d/%0d",
                 score_L, score_R, prev_l, prev_r);
        end
      end
      prev_l = score_L;
      prev_r = score_R;
    end
  end

  initial begin
    reset = 1'b0;
    key_L = 1'b0;
    key_R = 1'b0;

    el = CEN; esl = 0; esr = 0; ego = 0; ew = 2'b00;
    st(0, 0, 0);
    armed = 1'b1;
    repeat (5) st(0, 0, 1);

    el = oh(5); st(1, 0, 1); st(0, 0, 1);
    el = oh(6); st(1, 0, 1);
    repeat (5) st(1, 0, 1);
    st(0, 0, 1);
    st(1, 1, 1); st(0, 0, 1);
    el = oh(5); st(0, 1, 1); st(0, 0, 1);
    el = oh(4); st(0, 1, 1); st(0, 0, 1);

    for (int i = 5; i <= 8; i++) begin
      el = oh(i); st(1, 0, 1); st(0, 0, 1);
    end
    el = '0; esl = 1;
    st(1, 0, 1); st(0, 0, 1); st(1, 0, 1); st(0, 0, 1);
    el = CEN;
    st(1, 0, 1); st(1, 0, 1); st(0, 0, 1);

    for (int r = 1; r <= 2; r++) begin
      for (int i = 3; i >= 0; i--) begin
        el = oh(i); st(0, 1, 1); st(0, 0, 1);
      end
      el = '0; esr = 3'(r);
      st(0, 1, 1); st(0, 0, 1); st(0, 1, 1); st(0, 0, 1);
      if (r == 1) begin
        el = CEN;
      end else begin
        ego = 1; ew = 2'b01;
      end
      st(0, 0, 1);
    end

    st(1, 0, 1); st(0, 0, 1); st(0, 1, 1); st(0, 0, 1);
    st(1, 1, 1); st(0, 0, 1);

    el = CEN; esl = 0; esr = 0; ego = 0; ew = 2'b00;
    st(1, 0, 0); st(1, 0, 0); st(0, 0, 1);

    for (int i = 5; i <= 8; i++) begin
      el = oh(i); st(1, 0, 1); st(0, 0, 1);
    end
    el = '0; esl = 1;
    st(1, 0, 1); st(0, 0, 1);
    el = CEN; esl = 0;
    st(0, 0, 0);
    repeat (5) st(0, 0, 1);
    el = oh(5); st(1, 0, 1); st(0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
